pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_ctrl_stall_counter.sv | 21 ++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Memory-op encodings, register sentinel and the stall class enum.
package pipe_pkg;

  localparam logic [3:0] REG_NONE      = 4'hF;
  localparam logic [1:0] MEM_NONE      = 2'b11;
  localparam logic [1:0] MEM_LOAD      = 2'b01;
  localparam logic [1:0] MEM_STORE     = 2'b10;
  localparam int         PROG_ADDR_MSB = 15;

  typedef enum logic [2:0] {
    CLS_RUN,
    CLS_LU,
    CLS_FLUSH,
    CLS_RAM_RD,
    CLS_RAM_WR1,
    CLS_RAM_WR2
  } cls_e;

  function automatic logic is_load(input logic [1:0] m);
    return m == MEM_LOAD;
  endfunction

  function automatic logic is_store(input logic [1:0] m);
    return m == MEM_STORE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_counter.sv
// 16-bit saturating stall counter with synchronous clear.
// Ports: clk, rst (async high), clr, en -> count.
module stall_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller: classifies each cycle and decodes the
// pipeline hold/clear/freeze controls plus shared-RAM arbitration.
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rreg1,
  input  logic [3:0]  id_rreg2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [3:0]  ex_wreg,
  input  logic [1:0]  ex_controlmem,
  input  logic        ex_branch_taken,
  input  logic [1:0]  mem_controlmem,
  input  logic [15:0] mem_addr,
  input  logic        cnt_clr,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_clear,
  output logic        id_clear,
  output logic        pipe_freeze,
  output logic        ram_sel,
  output logic [15:0] stall_count
);

  cls_e state_q;
  cls_e cls;

  logic prog_hit;
  logic st_conf;
  logic ld_conf;
  logic load_use;
  logic raw_clear;
  logic unused_addr;

  assign unused_addr = ^mem_addr[PROG_ADDR_MSB-1:0];

  assign prog_hit = ~mem_addr[PROG_ADDR_MSB];
  assign st_conf  = is_store(mem_controlmem) & prog_hit;
  assign ld_conf  = is_load(mem_controlmem) & prog_hit;

  assign load_use = is_load(ex_controlmem) &&
                    ex_wreg != REG_NONE &&
                    ((id_use1 && id_rreg1 == ex_wreg) ||
                     (id_use2 && id_rreg2 == ex_wreg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CLS_RUN;
    else     state_q <= cls;
  end

  // RAM_WR1 always completes as RAM_WR2 regardless of inputs.
  always_comb begin
    cls = CLS_RUN;
    if (rst)                       cls = CLS_RUN;
    else if (state_q == CLS_RAM_WR1) cls = CLS_RAM_WR2;
    else if (st_conf)              cls = CLS_RAM_WR1;
    else if (ld_conf)              cls = CLS_RAM_RD;
    else if (ex_branch_taken)      cls = CLS_FLUSH;
    else if (load_use)             cls = CLS_LU;
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    raw_clear   = 1'b0;
    id_clear    = 1'b0;
    pipe_freeze = 1'b0;
    ram_sel     = 1'b0;
    unique case (cls)
      CLS_RUN: ;
      CLS_LU: begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        id_clear  = 1'b1;
      end
      CLS_FLUSH: begin
        raw_clear = 1'b1;
        id_clear  = 1'b1;
      end
      CLS_RAM_RD, CLS_RAM_WR2: begin
        ram_sel   = 1'b1;
        pc_hold   = 1'b1;
        raw_clear = 1'b1;
        // Fetch is lost this cycle; a taken branch still redirects
        // the PC, otherwise a load-use keeps the ID instruction.
        if (ex_branch_taken) begin
          id_clear = 1'b1;
          pc_hold  = 1'b0;
        end else if (load_use) begin
          ifid_hold = 1'b1;
          id_clear  = 1'b1;
        end
      end
      CLS_RAM_WR1: begin
        ram_sel     = 1'b1;
        pipe_freeze = 1'b1;
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ifid_clear = raw_clear & ~ifid_hold;

  stall_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cls != CLS_RUN),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl.
// Table of cycle vectors plus reset and saturation sequences.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  id_rreg1;
  logic [3:0]  id_rreg2;
  logic        id_use1;
  logic        id_use2;
  logic [3:0]  ex_wreg;
  logic [1:0]  ex_controlmem;
  logic        ex_branch_taken;
  logic [1:0]  mem_controlmem;
  logic [15:0] mem_addr;
  logic        cnt_clr;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_clear;
  logic        id_clear;
  logic        pipe_freeze;
  logic        ram_sel;
  logic [15:0] stall_count;

  int n_vec = 0;
  int n_bad = 0;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rreg1        (id_rreg1),
    .id_rreg2        (id_rreg2),
    .id_use1         (id_use1),
    .id_use2         (id_use2),
    .ex_wreg         (ex_wreg),
    .ex_controlmem   (ex_controlmem),
    .ex_branch_taken (ex_branch_taken),
    .mem_controlmem  (mem_controlmem),
    .mem_addr        (mem_addr),
    .cnt_clr         (cnt_clr),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_clear      (ifid_clear),
    .id_clear        (id_clear),
    .pipe_freeze     (pipe_freeze),
    .ram_sel         (ram_sel),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        u1;
    logic        u2;
    logic [3:0]  wreg;
    logic [1:0]  exm;
    logic        br;
    logic [1:0]  mm;
    logic [15:0] addr;
    logic        clr;
    logic [5:0]  exp;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[19];

  // exp = {pc_hold, ifid_hold, ifid_clear, id_clear, pipe_freeze, ram_sel}
  function automatic vec_t mk(
    input logic [3:0] r1, input logic [3:0] r2,
    input logic u1, input logic u2,
    input logic [3:0] wreg, input logic [1:0] exm,
    input logic br, input logic [1:0] mm,
    input logic [15:0] addr, input logic clr,
    input logic [5:0] exp, input logic [15:0] cnt);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
    v.wreg = wreg; v.exm = exm; v.br = br; v.mm = mm;
    v.addr = addr; v.clr = clr; v.exp = exp; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {pc_hold, ifid_hold, ifid_clear,
            id_clear, pipe_freeze, ram_sel};
  endfunction

  task automatic drive(input vec_t v);
    id_rreg1        = v.r1;
    id_rreg2        = v.r2;
    id_use1         = v.u1;
    id_use2         = v.u2;
    ex_wreg         = v.wreg;
    ex_controlmem   = v.exm;
    ex_branch_taken = v.br;
    mem_controlmem  = v.mm;
    mem_addr        = v.addr;
    cnt_clr         = v.clr;
  endtask

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  vec_t idle;

  initial begin
    idle = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b11,
              16'h0000, 0, 6'b000000, 16'd0);

    vecs[0]  = idle;
    vecs[1]  = mk(4'h3, 4'h0, 1, 0, 4'h3, 2'b01, 0, 2'b11,
                  16'h0000, 0, 6'b110100, 16'd0);
    vecs[2]  = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b11,
                  16'h0000, 0, 6'b000000, 16'd1);
    vecs[3]  = mk(4'h3, 4'h3, 0, 0, 4'h3, 2'b01, 0, 2'b11,
                  16'h0000, 0, 6'b000000, 16'd1);
    vecs[4]  = mk(4'hF, 4'h0, 1, 0, 4'hF, 2'b01, 0, 2'b11,
                  16'h0000, 0, 6'b000000, 16'd1);
    vecs[5]  = mk(4'h1, 4'h3, 1, 1, 4'h3, 2'b01, 0, 2'b11,
                  16'h0000, 0, 6'b110100, 16'd1);
    vecs[6]  = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 1, 2'b11,
                  16'h0000, 0, 6'b001100, 16'd2);
    vecs[7]  = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b10,
                  16'h4000, 0, 6'b110011, 16'd3);
    vecs[8]  = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b11,
                  16'h0000, 0, 6'b101001, 16'd4);
    vecs[9]  = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b10,
                  16'hBF00, 0, 6'b000000, 16'd5);
    vecs[10] = mk(4'h3, 4'h0, 1, 0, 4'h3, 2'b01, 0, 2'b01,
                  16'h0010, 0, 6'b110101, 16'd5);
    vecs[11] = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 1, 2'b01,
                  16'h0010, 0, 6'b001101, 16'd6);
    vecs[12] = mk(4'h3, 4'h0, 1, 0, 4'h3, 2'b01, 1, 2'b10,
                  16'h0000, 0, 6'b110011, 16'd7);
    vecs[13] = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 1, 2'b10,
                  16'h0000, 0, 6'b001101, 16'd8);
    vecs[14] = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b10,
                  16'h1000, 0, 6'b110011, 16'd9);
    vecs[15] = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b11,
                  16'h0000, 0, 6'b101001, 16'd10);
    vecs[16] = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 1, 2'b11,
                  16'h0000, 1, 6'b001100, 16'd11);
    vecs[17] = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b11,
                  16'h0000, 0, 6'b000000, 16'd0);
    vecs[18] = mk(4'h0, 4'h0, 0, 0, 4'hF, 2'b11, 0, 2'b00,
                  16'h0000, 0, 6'b000000, 16'd0);

    drive(idle);
    rst = 1'b1;
    #1;
    check("reset_outs", {10'd0, outs()}, 16'd0);
    check("reset_cnt", stall_count, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d_outs", i),
            {10'd0, outs()}, {10'd0, vecs[i].exp});
      check($sformatf("v%0d_cnt", i),
            stall_count, vecs[i].cnt);
    end

    // Reset in the middle of a store sequence.
    @(negedge clk);
    drive(idle);
    mem_controlmem = 2'b10;
    mem_addr       = 16'h0000;
    @(posedge clk);
    #2;
    check("wr2_pre_rst", {10'd0, outs()}, 16'b101001);
    check("cnt_pre_rst", stall_count, 16'd1);
    rst = 1'b1;
    #1;
    check("rst_wr_outs", {10'd0, outs()}, 16'd0);
    check("rst_wr_cnt", stall_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_wr1", {10'd0, outs()}, 16'b110011);
    @(negedge clk);
    drive(idle);
    #2;
    check("post_rst_wr2", {10'd0, outs()}, 16'b101001);
    check("post_rst_cnt", stall_count, 16'd1);

    // Saturation: stall 65535 cycles from zero, then keep stalling.
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    ex_branch_taken = 1'b1;
    #2;
    check("sat_start", stall_count, 16'd0);
    repeat (65535) @(posedge clk);
    #2;
    check("sat_reach", stall_count, 16'hFFFF);
    repeat (3) @(posedge clk);
    #2;
    check("sat_hold", stall_count, 16'hFFFF);
    @(negedge clk);
    drive(idle);
    #2;
    check("sat_idle_outs", {10'd0, outs()}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
